// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, mul/div op codes, sequencer states and negation helpers.
package alu_pkg;
  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared Addu/Subu ALU.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [31:0] DZ_LO = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic is_div, sgn, do_sub;
  logic [31:0] ma, mb, trial;
  logic [32:0] sum;
  logic [63:0] prod;
  // a_q is acc/rem, q_q is multiplier/quotient, b_q is multiplicand/divisor
  assign is_div = op_q[1];
  assign sgn    = op_q[0];
  assign ma     = sgn && a_q[31] ? neg32(a_q) : a_q;
  assign mb     = sgn && b_q[31] ? neg32(b_q) : b_q;
  assign trial  = {a_q[30:0], q_q[31]};
  assign prod   = neg_q ? neg64({a_q, q_q}) : {a_q, q_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULTU;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = ALUC_ADDU;
    do_sub   = 1'b0;
    sum      = {1'b0, a_q};
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PREP;
        op_d    = op;
        a_d     = rs_data;
        b_d     = rt_data;
        dz_d    = 1'b0;
      end
      S_PREP: begin
        cnt_d   = '0;
        neg_d   = sgn & (a_q[31] ^ b_q[31]);
        rneg_d  = sgn & a_q[31];
        a_d     = '0;
        b_d     = is_div ? mb : ma;
        q_d     = is_div ? ma : mb;
        state_d = S_CALC;
        if (is_div && b_q == '0) begin
          state_d = S_DONE;
          hi_d    = a_q;
          lo_d    = DZ_LO;
          dz_d    = 1'b1;
        end
      end
      S_CALC: begin
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? S_FIX : S_CALC;
        alu_a   = is_div ? trial : a_q;
        alu_b   = b_q;
        if (is_div) begin
          alu_aluc = ALUC_SUBU;
          // rem[31] set means trial's lost bit 32 was 1, so it always exceeds the divisor
          do_sub   = !alu_carry || a_q[31];
          a_d      = do_sub ? alu_r : trial;
          q_d      = {q_q[30:0], do_sub};
        end else begin
          sum        = q_q[0] ? {alu_carry, alu_r} : {1'b0, a_q};
          {a_d, q_d} = {sum, q_q[31:1]};
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d    = is_div ? (rneg_q ? neg32(a_q) : a_q) : prod[63:32];
        lo_d    = is_div ? (neg_q ? neg32(q_q) : q_q) : prod[31:0];
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vectors through a scoreboard, with an inline Addu/Subu ALU.
module tb_alu_muldiv_seq;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, alu_carry;
  logic [1:0] op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0, alu_a, alu_b, alu_r, hi, lo;
  logic [3:0] alu_aluc;
  logic busy, done, div_zero;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb {alu_carry, alu_r} = alu_aluc == ALUC_SUBU ? {1'b0, alu_a} - {1'b0, alu_b}
                                                         : {1'b0, alu_a} + {1'b0, alu_b};

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r), .alu_carry(alu_carry),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency", cyc - t0, e.lat);
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ez,
                     input int lat, input bit disturb);
    exp_t e;
    int n;
    @(negedge clk);
    e = '{hi: eh, lo: el, dz: ez, lat: lat};
    sb.push_back(e);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1 t0 = cyc;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("dz_cleared_on_start", 32'(div_zero), 32'd0);
    start = 1'b0; op = ~o; rs_data = ~a; rt_data = ~b;
    if (disturb) begin
      repeat (5) @(negedge clk);
      start = 1'b1; op = MD_DIVU; rs_data = 32'd9; rt_data = 32'd0;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end else begin
      start = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("start_in_done_ignored", 32'(busy), 32'd0);
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_aluc", 32'(alu_aluc), 32'(ALUC_ADDU));
    rst = 1'b0;
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b0);
    run(MD_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 1'b0);
    run(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 1'b0);
    run(MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 1'b0);
    run(MD_MULTU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 34, 1'b0);
    run(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 1'b0);
    run(MD_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0, 34, 1'b0);
    run(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    run(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1'b0);
    run(MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run(MD_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run(MD_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 34, 1'b1);
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; rs_data = 32'd1234; rt_data = 32'd5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
